fifo_packer: RTL and testbench

FIFO_PACKER -- requirements
Module: fifo_packer

---
 rtl/fifo_pkg.sv | 4 +
 rtl/fifo_packer.sv | 63 ++++++
 tb/tb_fifo_packer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO-path types for the packer and its neighbours.
package fifo_pkg;
  typedef enum logic {FILL, EMIT} pack_state_e;
endpackage

// File: rtl/fifo_packer.sv
// fifo_packer: pops FIFO entries into LSB-first lanes and presents full or flushed words.
module fifo_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_COUNT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_read,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data,
  output logic [$clog2(PACK_COUNT+1)-1:0]  out_count,
  output logic                             busy
);
  localparam int CW = $clog2(PACK_COUNT + 1);
  pack_state_e                      state_q, state_d;
  logic [CW-1:0]                    count_q, count_d;
  logic [DATA_WIDTH*PACK_COUNT-1:0] lanes_q, lanes_d;
  logic                             flush_pending_q, flush_pending_d;
  assign fifo_read = !rst && state_q == FILL && !fifo_empty;
  assign out_valid = !rst && state_q == EMIT;
  assign out_data  = rst ? '0 : lanes_q;
  assign out_count = out_valid ? count_q : '0;
  assign busy      = !rst && (count_q != '0 || out_valid);
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    lanes_d         = lanes_q;
    flush_pending_d = flush_pending_q | flush;
    for (int i = 0; i < PACK_COUNT; i++)
      lanes_d[i*DATA_WIDTH +: DATA_WIDTH] = (fifo_read && count_q == CW'(i)) ? fifo_data : lanes_q[i*DATA_WIDTH +: DATA_WIDTH];
    if (fifo_read) begin
      count_d = count_q + CW'(1);
      state_d = (count_q == CW'(PACK_COUNT - 1)) ? EMIT : FILL;
    end else if (state_q == FILL && flush_pending_q) begin
      // a flush arriving on the flush-triggered transition is absorbed
      state_d         = (count_q != '0) ? EMIT : FILL;
      flush_pending_d = (count_q != '0) ? 1'b0 : flush;
    end
    if (state_q == EMIT && out_ready) begin
      state_d = FILL;
      count_d = '0;
      lanes_d = '0;
    end
    if (rst) begin
      state_d         = FILL;
      count_d         = '0;
      lanes_d         = '0;
      flush_pending_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    state_q         <= state_d;
    count_q         <= count_d;
    lanes_q         <= lanes_d;
    flush_pending_q <= flush_pending_d;
  end
endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: directed and randomized checks of fifo_packer against a FIFO/word-stream model.
module tb_fifo_packer;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, out_ready = 1'b1;
  logic        fifo_empty, fifo_read, out_valid, busy, rd;
  logic [3:0]  fifo_data, d;
  logic [15:0] out_data, acc, held, ex;
  logic [2:0]  out_count;
  logic [3:0]  q[$];
  logic [15:0] exp_q[$];
  int n_chk = 0, n_fail = 0, n, k, pushed, cycles;
  logic hold;

  always #5 clk = ~clk;

  fifo_packer dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? 4'h0 : q[0];
  endtask

  task automatic push(input logic [3:0] v);
    q.push_back(v);
    drive();
  endtask

  task automatic cyc();
    #1;
    rd = fifo_read;
    @(posedge clk);
    if (rd) void'(q.pop_front());
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic until_valid(input string tag, input int lim);
    n = 0;
    while (!out_valid && n < lim) begin
      cyc();
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    drive();
    for (int i = 1; i <= 8; i++) push(4'(i));
    @(negedge clk);
    cyc();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_read", 32'(fifo_read), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_data", 32'(out_data), 0);
    cyc();
    chk("rst_qkept", 32'(q.size()), 8);
    // continuous stream
    rst = 1'b0;
    until_valid("a_to1", 20);
    chk("a_lat1", 32'(n), 4);
    chk("a_w1", 32'(out_data), 32'h4321);
    chk("a_c1", 32'(out_count), 4);
    chk("a_rd_emit", 32'(fifo_read), 0);
    cyc();
    until_valid("a_to2", 20);
    chk("a_gap", 32'(n + 1), 5);
    chk("a_w2", 32'(out_data), 32'h8765);
    chk("a_c2", 32'(out_count), 4);
    cyc();
    chk("a_idle_valid", 32'(out_valid), 0);
    chk("a_idle_busy", 32'(busy), 0);
    // backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(4'(i));
    until_valid("b_to", 20);
    push(4'h5);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("b_hold_valid", 32'(out_valid), 1);
      chk("b_hold_data", 32'(out_data), 32'h4321);
      chk("b_hold_read", 32'(fifo_read), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("b_hs_read", 32'(fifo_read), 0);
    cyc();
    chk("b_after_valid", 32'(out_valid), 0);
    chk("b_after_q", 32'(q.size()), 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    until_valid("b_fl_to", 10);
    chk("b_fl_data", 32'(out_data), 32'h0005);
    chk("b_fl_count", 32'(out_count), 1);
    cyc();
    // partial flush
    push(4'hA);
    push(4'hB);
    cyc();
    cyc();
    chk("c_busy", 32'(busy), 1);
    chk("c_novalid", 32'(out_valid), 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    until_valid("c_to", 10);
    chk("c_lat", 32'(n), 1);
    chk("c_data", 32'(out_data), 32'h00BA);
    chk("c_count", 32'(out_count), 2);
    cyc();
    chk("c_busy_end", 32'(busy), 0);
    // empty flush emits nothing and leaves no pending flush behind
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("d_novalid", 32'(out_valid), 0);
      chk("d_busy", 32'(busy), 0);
    end
    push(4'h1);
    push(4'h2);
    push(4'h3);
    for (int i = 0; i < 5; i++) cyc();
    chk("d_no_stale_flush", 32'(out_valid), 0);
    chk("d_busy3", 32'(busy), 1);
    // reset mid-word
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("e_busy", 32'(busy), 0);
    chk("e_valid", 32'(out_valid), 0);
    push(4'h9);
    push(4'h8);
    push(4'h7);
    push(4'h6);
    until_valid("e_to", 20);
    chk("e_lat", 32'(n), 4);
    chk("e_data", 32'(out_data), 32'h6789);
    chk("e_count", 32'(out_count), 4);
    cyc();
    // reset during emit discards the pending word
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(4'(i));
    until_valid("f_to", 20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("f_valid", 32'(out_valid), 0);
      chk("f_busy", 32'(busy), 0);
    end
    // flush with data pending
    for (int i = 1; i <= 6; i++) push(4'(i));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    until_valid("g_to1", 20);
    chk("g_w1", 32'(out_data), 32'h4321);
    chk("g_c1", 32'(out_count), 4);
    cyc();
    until_valid("g_to2", 20);
    chk("g_w2", 32'(out_data), 32'h0065);
    chk("g_c2", 32'(out_count), 2);
    cyc();
    chk("g_busy", 32'(busy), 0);
    // randomized stream vs. grouped-word model
    acc = '0; k = 0; pushed = 0; cycles = 0; hold = 1'b0; held = '0;
    while ((pushed < 40 || exp_q.size() > 0) && cycles < 3000) begin
      if (pushed < 40 && $urandom_range(1) == 1) begin
        d = 4'($urandom_range(15));
        push(d);
        acc = {d, acc[15:4]};
        k++;
        pushed++;
        if (k == 4) begin
          exp_q.push_back(acc);
          k = 0;
        end
      end
      out_ready = 1'($urandom_range(1));
      #1;
      chk("r_read", 32'(fifo_read), 32'(!fifo_empty && !out_valid));
      if (hold) begin
        chk("r_stable_valid", 32'(out_valid), 1);
        chk("r_stable_data", 32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        ex = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
        chk("r_word", 32'(out_data), 32'(ex));
        chk("r_count", 32'(out_count), 4);
        hold = 1'b0;
      end else begin
        hold = out_valid;
        held = out_data;
      end
      cyc();
      cycles++;
    end
    chk("r_done", 32'(pushed == 40 && exp_q.size() == 0), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
